// File: rtl/instruction_encoder.sv
// LEGv8 instruction assembler: turns decoded field bundles into machine words and
// streams them, with their instruction-memory byte addresses, to the program loader.
module instruction_encoder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 1024,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rn,
  input  logic [4:0]            in_rm,
  input  logic [25:0]           in_imm,
  input  logic [5:0]            in_shamt,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADDI  = 4'd0;
  localparam logic [3:0] OP_ADDS  = 4'd1;
  localparam logic [3:0] OP_SUBS  = 4'd2;
  localparam logic [3:0] OP_B     = 4'd3;
  localparam logic [3:0] OP_BL    = 4'd4;
  localparam logic [3:0] OP_BCOND = 4'd5;
  localparam logic [3:0] OP_CBZ   = 4'd6;
  localparam logic [3:0] OP_BR    = 4'd7;
  localparam logic [3:0] OP_LDUR  = 4'd8;
  localparam logic [3:0] OP_STUR  = 4'd9;

  localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_instr_q, out_instr_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  start_ok;
  logic [ADDR_WIDTH:0]   word_count_inc;
  logic                  imm12_ok, imm19_ok, imm9_ok;
  logic                  enc_legal;
  logic [31:0]           enc_word;

  // Signed immediates are legal only when the discarded upper bits are pure sign extension.
  assign imm12_ok = (in_imm[25:12] == 14'd0);
  assign imm19_ok = (in_imm[25:18] == {8{in_imm[18]}});
  assign imm9_ok  = (in_imm[25:8] == {18{in_imm[8]}});

  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b0;
    case (in_op)
      OP_ADDI: begin
        enc_word  = {10'b1001000100, in_imm[11:0], in_rn, in_rd};
        enc_legal = imm12_ok;
      end
      OP_ADDS: begin
        enc_word  = {11'b10101011000, in_rm, in_shamt, in_rn, in_rd};
        enc_legal = 1'b1;
      end
      OP_SUBS: begin
        enc_word  = {11'b11101011000, in_rm, in_shamt, in_rn, in_rd};
        enc_legal = 1'b1;
      end
      OP_B: begin
        enc_word  = {6'b000101, in_imm};
        enc_legal = 1'b1;
      end
      OP_BL: begin
        enc_word  = {6'b100101, in_imm};
        enc_legal = 1'b1;
      end
      OP_BCOND: begin
        enc_word  = {8'b01010100, in_imm[18:0], 1'b0, in_rd[3:0]};
        enc_legal = imm19_ok;
      end
      OP_CBZ: begin
        enc_word  = {8'b10110100, in_imm[18:0], in_rd};
        enc_legal = imm19_ok;
      end
      OP_BR: begin
        enc_word  = {11'b11010110000, 11'b11111000000, in_rd, in_rd};
        enc_legal = 1'b1;
      end
      OP_LDUR: begin
        enc_word  = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
        enc_legal = imm9_ok;
      end
      OP_STUR: begin
        enc_word  = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
        enc_legal = imm9_ok;
      end
      default: begin
        enc_word  = 32'd0;
        enc_legal = 1'b0;
      end
    endcase
  end

  assign in_ready       = (state_q == S_LOAD) && (!out_valid_q || out_ready);
  assign accept         = in_valid && in_ready;
  assign start_ok       = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign word_count_inc = word_count_q + 1'b1;

  // FSM process 1: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM process 2: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if ((accept && (in_last || (enc_legal && (word_count_inc == DEPTH_W)))) ||
            (word_count_q >= DEPTH_W)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!out_valid_q || out_ready) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM process 3: status outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_LOAD, S_DRAIN: busy = 1'b1;
      S_DONE:          done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // A new legal word overwrites the output register in the same cycle the old one is taken.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_addr_d   = out_addr_q;
    word_count_d = word_count_q;
    err_d        = err_q;
    if (start_ok) begin
      word_count_d = '0;
      err_d        = 1'b0;
    end
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (enc_legal) begin
        out_valid_d  = 1'b1;
        out_instr_d  = enc_word;
        out_addr_d   = BASE + {word_count_q[ADDR_WIDTH-3:0], 2'b00};
        word_count_d = word_count_inc;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= 32'd0;
      out_addr_q   <= BASE;
      word_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_addr_q   <= out_addr_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_addr   = out_addr_q;
  assign word_count = word_count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: directed field bundles plus randomized sessions
// against an arithmetic model of the LEGv8 encodings.
module tb_instruction_encoder;
  localparam int ADDR_WIDTH = 12;
  localparam int DEPTH      = 4;
  localparam int BASE_ADDR  = 0;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [3:0]            in_op = '0;
  logic [4:0]            in_rd = '0, in_rn = '0, in_rm = '0;
  logic [25:0]           in_imm = '0;
  logic [5:0]            in_shamt = '0;
  logic                  in_last = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [31:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  busy, done, err;

  instruction_encoder #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .reset(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .in_shamt(in_shamt), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .word_count(word_count),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   bp_mode = 0;   // 0 always ready, 1 random backpressure, 2 stalled
  int   m_wc = 0;
  bit   m_err = 0;
  bit   m_ended = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Encodings built from field values with integer arithmetic; legality from signed ranges.
  function automatic bit model_encode(input int op, input int rd, input int rn, input int rm,
                                      input int shamt, input logic [25:0] imm,
                                      output logic [31:0] w);
    int u, s;
    u = int'(imm);
    s = (u >= (1 << 25)) ? u - (1 << 26) : u;
    w = 32'd0;
    case (op)
      0: begin w = (32'h244 << 22) | (u << 10) | (rn << 5) | rd; return u < 4096; end
      1: begin w = (32'h558 << 21) | (rm << 16) | (shamt << 10) | (rn << 5) | rd; return 1; end
      2: begin w = (32'h758 << 21) | (rm << 16) | (shamt << 10) | (rn << 5) | rd; return 1; end
      3: begin w = (32'h05 << 26) | u; return 1; end
      4: begin w = (32'h25 << 26) | u; return 1; end
      5: begin w = (32'h54 << 24) | ((s & 32'h7FFFF) << 5) | (rd % 16);
               return (s >= -(1 << 18)) && (s < (1 << 18)); end
      6: begin w = (32'hB4 << 24) | ((s & 32'h7FFFF) << 5) | rd;
               return (s >= -(1 << 18)) && (s < (1 << 18)); end
      7: begin w = (32'h6B0 << 21) | (32'h7C0 << 10) | (rd << 5) | rd; return 1; end
      8: begin w = (32'h7C2 << 21) | ((s & 32'h1FF) << 12) | (rn << 5) | rd;
               return (s >= -256) && (s < 256); end
      9: begin w = (32'h7C0 << 21) | ((s & 32'h1FF) << 12) | (rn << 5) | rd;
               return (s >= -256) && (s < 256); end
      default: return 0;
    endcase
  endfunction

  always begin
    @(negedge clk);
    case (bp_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom % 3) != 0;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops on every output handshake and checks hold stability under backpressure.
  bit          prev_stall = 0;
  logic [31:0] prev_instr;
  logic [ADDR_WIDTH-1:0] prev_addr;
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_instr", out_instr, prev_instr);
        chk("hold_addr", 32'(out_addr), 32'(prev_addr));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_word", out_instr, 32'hxxxxxxxx);
        end else begin
          e = sb.pop_front();
          chk("sb_instr", out_instr, e.instr);
          chk("sb_addr", 32'(out_addr), e.addr);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_addr  = out_addr;
    end
  end

  task automatic issue(input int op, input int rd, input int rn, input int rm,
                       input logic [25:0] imm, input int shamt, input bit last);
    logic [31:0] w;
    bit lg, acc;
    int n;
    exp_t e;
    lg = model_encode(op, rd, rn, rm, shamt, imm, w);
    @(negedge clk);
    in_op = 4'(op); in_rd = 5'(rd); in_rn = 5'(rn); in_rm = 5'(rm);
    in_imm = imm; in_shamt = 6'(shamt); in_last = last; in_valid = 1'b1;
    acc = 0; n = 0;
    while (1) begin
      #1;
      acc = in_ready;
      @(posedge clk);
      if (acc || n >= 200) break;
      n++;
      @(negedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    if (lg) begin
      e.instr = w;
      e.addr  = 32'(BASE_ADDR + 4 * m_wc);
      sb.push_back(e);
      m_wc++;
      if (last || m_wc == DEPTH) m_ended = 1;
      chk("latency_valid", 32'(out_valid), 32'd1);
      chk("latency_instr", out_instr, w);
    end else begin
      m_err = 1;
      if (last) m_ended = 1;
      chk("illegal_err", 32'(err), 32'd1);
      chk("illegal_no_out", 32'(out_valid), 32'd0);
    end
    chk("word_count", 32'(word_count), 32'(m_wc));
  endtask

  task automatic start_session();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m_wc = 0; m_err = 0; m_ended = 0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_wc_clear", 32'(word_count), 32'd0);
    chk("start_err_clear", 32'(err), 32'd0);
  endtask

  task automatic finish_session();
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      #1;
      if (done) break;
      n++;
    end
    chk("session_done", 32'(done), 32'd1);
    chk("session_idle_busy", 32'(busy), 32'd0);
    chk("session_wc", 32'(word_count), 32'(m_wc));
    chk("session_err", 32'(err), 32'(m_err));
    chk("session_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic rand_bundle(output int op, output int rd, output int rn, output int rm,
                             output logic [25:0] imm, output int shamt);
    int v;
    int edges[10] = '{-257, -256, 255, 256, 4095, 4096,
                      -(1 << 18) - 1, -(1 << 18), (1 << 18) - 1, 1 << 18};
    op = (($urandom % 8) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
    rd = int'($urandom % 32); rn = int'($urandom % 32); rm = int'($urandom % 32);
    shamt = int'($urandom % 64);
    case ($urandom % 4)
      0: v = int'($urandom);
      1: v = int'($urandom_range(0, 511)) - 256;
      2: v = edges[$urandom % 10];
      default: v = int'($urandom_range(0, 4095));
    endcase
    imm = v[25:0];
  endtask

  initial begin
    #400000;
    chk("watchdog", 32'd0, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int op, rd, rn, rm, shamt, len;
    logic [25:0] imm;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'(BASE_ADDR));
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Directed encodings with fixed reference words
    start_session();
    issue(0, 15, 11, 0, 26'h07E, 0, 0);
    chk("T1_addi_word", out_instr, 32'h9101F96F);
    chk("T1_addi_addr", 32'(out_addr), 32'h000);
    issue(2, 2, 19, 30, 26'h0, 0, 0);
    chk("T2_subs_word", out_instr, 32'hEB1E0262);
    issue(3, 0, 0, 0, 26'h3FFFFFF, 0, 0);
    chk("T2_b_word", out_instr, 32'h17FFFFFF);
    issue(5, 3, 0, 0, 26'd32, 0, 1);
    chk("T2_bcond_word", out_instr, 32'h54000403);
    finish_session();

    start_session();
    issue(8, 0, 1, 0, 26'h3FFFEFF, 0, 0);
    issue(8, 0, 1, 0, 26'h3FFFF00, 0, 1);
    chk("T3_ldur_word", out_instr, 32'hF8500020);
    finish_session();

    // Backpressure: first word stalls, the next two wait behind it
    bp_mode = 2;
    start_session();
    issue(1, 1, 2, 3, 26'h0, 5, 0);
    fork
      begin
        issue(7, 9, 0, 0, 26'h0, 0, 0);
        issue(4, 0, 0, 0, 26'h1234567, 0, 1);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          #1;
          chk("T4_in_ready_low", 32'(in_ready), 32'd0);
          chk("T4_held_addr", 32'(out_addr), 32'(BASE_ADDR));
        end
        bp_mode = 0;
      end
    join
    finish_session();

    // Depth limit: extra bundles must be refused, then restart from BASE_ADDR
    start_session();
    for (int i = 0; i < DEPTH; i++) issue(0, i, i, 0, 26'(i * 8), 0, 0);
    repeat (3) begin
      @(negedge clk);
      in_op = 4'd0; in_valid = 1'b1;
      #1;
      chk("T5_depth_refused", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    finish_session();
    start_session();
    issue(3, 0, 0, 0, 26'd100, 0, 1);
    finish_session();

    // Randomized sessions under random backpressure
    bp_mode = 1;
    for (int s = 0; s < 40; s++) begin
      start_session();
      len = int'($urandom_range(1, 7));
      for (int i = 0; i < len; i++) begin
        if (m_ended) break;
        if (i == 1 && ($urandom % 2) == 1) begin
          @(negedge clk);
          start = 1'b1;
          @(posedge clk);
          #1;
          start = 1'b0;
          chk("start_ignored_wc", 32'(word_count), 32'(m_wc));
          chk("start_ignored_busy", 32'(busy), 32'd1);
        end
        rand_bundle(op, rd, rn, rm, imm, shamt);
        issue(op, rd, rn, rm, imm, shamt, i == len - 1);
      end
      finish_session();
    end

    // Reset mid-session with a word pending and err set
    bp_mode = 0;
    start_session();
    issue(8, 0, 0, 0, 26'h3FFFEFF, 0, 0);
    bp_mode = 2;
    issue(0, 4, 5, 0, 26'd7, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("T6_out_valid", 32'(out_valid), 32'd0);
    chk("T6_busy", 32'(busy), 32'd0);
    chk("T6_done", 32'(done), 32'd0);
    chk("T6_err", 32'(err), 32'd0);
    chk("T6_wc", 32'(word_count), 32'd0);
    chk("T6_out_addr", 32'(out_addr), 32'(BASE_ADDR));
    sb.delete();
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    bp_mode = 0;
    start_session();
    issue(6, 7, 0, 0, 26'h3FC0000, 0, 1);
    finish_session();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
